// File: rtl/seg_dynamic_scan.sv
// rtl/seg_dynamic_scan.sv - time-multiplexed common-anode 7-segment hex driver
// Scans one digit per dwell period; data is snapshotted once per frame so the display never tears.
module seg_dynamic_scan #(
  parameter int          DIGITS   = 6,
  parameter int unsigned SCAN_MAX = 16'd49_999,
  parameter int          CNT_W    = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   point,
  input  logic                blank_lz,
  input  logic                enable,
  output logic [DIGITS-1:0]   sel,
  output logic [7:0]          seg,
  output logic                frame_done
);

  localparam int                IDX_W    = $clog2(DIGITS);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_MAX);
  localparam logic [DIGITS-1:0] SEL_ONE  = DIGITS'(1);

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] snap_data;
  logic [DIGITS-1:0]   snap_point;
  logic                snap_blank_lz;
  logic                tick;
  logic                wrap;
  logic [3:0]          cur_nib;
  logic                cur_point;
  logic                cur_blank;
  logic                zero_above;

  assign tick = (cnt == CNT_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    case (nib)
      4'h0: seg_code = 7'h40;
      4'h1: seg_code = 7'h79;
      4'h2: seg_code = 7'h24;
      4'h3: seg_code = 7'h30;
      4'h4: seg_code = 7'h19;
      4'h5: seg_code = 7'h12;
      4'h6: seg_code = 7'h02;
      4'h7: seg_code = 7'h78;
      4'h8: seg_code = 7'h00;
      4'h9: seg_code = 7'h10;
      4'hA: seg_code = 7'h08;
      4'hB: seg_code = 7'h03;
      4'hC: seg_code = 7'h46;
      4'hD: seg_code = 7'h21;
      4'hE: seg_code = 7'h06;
      default: seg_code = 7'h0E;
    endcase
  endfunction

  // Walk from the most significant digit down so zero_above tracks "all nibbles from the top to here are 0".
  always_comb begin
    cur_nib    = 4'd0;
    cur_point  = 1'b0;
    cur_blank  = 1'b0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (snap_data[4*i +: 4] == 4'd0);
      if (idx == IDX_W'(i)) begin
        cur_nib   = snap_data[4*i +: 4];
        cur_point = snap_point[i];
        cur_blank = snap_blank_lz && zero_above && (i != 0);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt           <= '0;
      idx           <= '0;
      snap_data     <= '0;
      snap_point    <= '0;
      snap_blank_lz <= 1'b0;
      sel           <= '0;
      seg           <= 8'hFF;
      frame_done    <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
      if (wrap) begin
        snap_data     <= data;
        snap_point    <= point;
        snap_blank_lz <= blank_lz;
      end
      frame_done <= wrap;
      // Outputs follow the current idx, so they lag an idx change by one cycle.
      if (enable) begin
        sel <= SEL_ONE << idx;
        seg <= {~cur_point, cur_blank ? 7'h7F : seg_code(cur_nib)};
      end else begin
        sel <= '0;
        seg <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_dynamic_scan.sv
// tb/tb_seg_dynamic_scan.sv - directed table-driven bench for seg_dynamic_scan
module tb_seg_dynamic_scan;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [23:0] data;
  logic [5:0]  point;
  logic        blank_lz;
  logic        enable;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_dynamic_scan #(
    .DIGITS   (6),
    .SCAN_MAX (3),
    .CNT_W    (4)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .data       (data),
    .point      (point),
    .blank_lz   (blank_lz),
    .enable     (enable),
    .sel        (sel),
    .seg        (seg),
    .frame_done (frame_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [23:0] data;
    logic [5:0]  point;
    logic        blz;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_frame();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (frame_done) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wait_frame: got no frame_done expected pulse within 60 cycles");
    end
  endtask

  // Steps s = from..to of a frame; step 1 is the first cycle after the frame_done sample.
  task automatic run_steps(input logic [47:0] exp, input int from, input int to);
    logic [5:0] one;
    int d;
    one = 6'd1;
    for (int s = from; s <= to; s++) begin
      step();
      d = (s - 1) / 4;
      chk("sel", 32'(sel), 32'(one << d));
      chk("seg", 32'(seg), 32'(exp[8*d +: 8]));
      chk("frame_done", 32'(frame_done), 32'(s == 24));
    end
  endtask

  // Cycles after reset release: zero snapshot, so every digit shows "0".
  task automatic start_seq(input int ncyc);
    logic [5:0] one;
    int d;
    one = 6'd1;
    for (int n = 1; n <= ncyc; n++) begin
      step();
      d = ((n - 1) / 4) % 6;
      chk("start_sel", 32'(sel), 32'(one << d));
      chk("start_seg", 32'(seg), 32'h0000_00C0);
      chk("start_frame_done", 32'(frame_done), 32'(n == 24));
    end
  endtask

  initial begin
    vecs[0] = '{24'h1234AB, 6'b000000, 1'b0, 48'hF9A4B0998883};
    vecs[1] = '{24'h000050, 6'b000000, 1'b1, 48'hFFFFFFFF92C0};
    vecs[2] = '{24'h000000, 6'b000000, 1'b1, 48'hFFFFFFFFFFC0};
    vecs[3] = '{24'h000000, 6'b000100, 1'b1, 48'hFFFFFF7FFFC0};
    vecs[4] = '{24'h0A0000, 6'b100001, 1'b1, 48'h7F88C0C0C040};
    vecs[5] = '{24'hFEDC98, 6'b111111, 1'b0, 48'h0E0621461000};
    vecs[6] = '{24'h765000, 6'b000000, 1'b1, 48'hF88292C0C0C0};

    sys_rst_n = 1'b0;
    enable    = 1'b1;
    data      = vecs[0].data;
    point     = vecs[0].point;
    blank_lz  = vecs[0].blz;
    repeat (3) step();
    chk("reset_sel", 32'(sel), 32'h0);
    chk("reset_seg", 32'(seg), 32'hFF);
    chk("reset_frame_done", 32'(frame_done), 32'h0);

    sys_rst_n = 1'b1;
    start_seq(24);
    run_steps(vecs[0].exp, 1, 24);

    for (int v = 0; v < 7; v++) begin
      data     = vecs[v].data;
      point    = vecs[v].point;
      blank_lz = vecs[v].blz;
      wait_frame();
      run_steps(vecs[v].exp, 1, 24);
    end

    // Mid-frame data change must not show until the next snapshot.
    data     = vecs[0].data;
    point    = vecs[0].point;
    blank_lz = vecs[0].blz;
    wait_frame();
    run_steps(vecs[0].exp, 1, 12);
    data     = vecs[5].data;
    point    = vecs[5].point;
    blank_lz = vecs[5].blz;
    run_steps(vecs[0].exp, 13, 24);
    run_steps(vecs[5].exp, 1, 24);

    // Enable dropped for 10 cycles; the scan position must keep advancing underneath.
    run_steps(vecs[5].exp, 1, 10);
    enable = 1'b0;
    for (int s = 11; s <= 20; s++) begin
      step();
      chk("dis_sel", 32'(sel), 32'h0);
      chk("dis_seg", 32'(seg), 32'hFF);
      chk("dis_frame_done", 32'(frame_done), 32'h0);
    end
    enable = 1'b1;
    run_steps(vecs[5].exp, 21, 24);

    // Asynchronous reset while digit 4 is displayed.
    run_steps(vecs[5].exp, 1, 17);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_sel", 32'(sel), 32'h0);
    chk("midrst_seg", 32'(seg), 32'hFF);
    chk("midrst_frame_done", 32'(frame_done), 32'h0);
    step();
    step();
    sys_rst_n = 1'b1;
    start_seq(24);
    run_steps(vecs[5].exp, 1, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
